// File: rtl/adder_tree_operand_loader.sv
// Serial-to-parallel operand collector feeding the adder tree leaves.
// Packs up to NUM_OPERANDS words per frame, zero-fills unused lanes, holds the frame under valid/ready.
module adder_tree_operand_loader #(
    parameter int unsigned ADDER_WIDTH  = 23,
    parameter int unsigned NUM_OPERANDS = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ADDER_WIDTH-1:0]                in_data,
    input  logic                                  in_valid,
    input  logic                                  in_last,
    output logic                                  in_ready,
    output logic [NUM_OPERANDS*ADDER_WIDTH-1:0]   out_data,
    output logic [$clog2(NUM_OPERANDS):0]         out_count,
    output logic                                  out_valid,
    input  logic                                  out_ready
);

    localparam int unsigned PTR_W = $clog2(NUM_OPERANDS);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_OPERANDS - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PTR_W-1:0]       ptr_q;
    logic [PTR_W-1:0]       ptr_d;
    logic [ADDER_WIDTH-1:0] lane_q [NUM_OPERANDS];
    logic [ADDER_WIDTH-1:0] lane_d [NUM_OPERANDS];
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   valid_q;

    logic                   accept;
    logic                   close;
    logic [PTR_W-1:0]       wr_idx;

    // A HOLD-state handshake may take the first word of the next frame in the same cycle.
    assign in_ready = (state_q == FILL) | ((state_q == HOLD) & out_ready);
    assign accept   = in_valid & in_ready;
    assign wr_idx   = (state_q == FILL) ? ptr_q : '0;
    assign close    = accept & (in_last | ((state_q == FILL) & (ptr_q == LAST_PTR)));

    // State register plus datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            ptr_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            valid_q <= (state_d == HOLD);
            lane_q  <= lane_d;
        end
    end

    // Next-state and lane pointer
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            FILL: begin
                if (close) begin
                    state_d = HOLD;
                    ptr_d   = '0;
                end else if (accept) begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (close) begin
                        state_d = HOLD;
                        ptr_d   = '0;
                    end else if (accept) begin
                        state_d = FILL;
                        ptr_d   = PTR_W'(1);
                    end else begin
                        state_d = FILL;
                        ptr_d   = '0;
                    end
                end
            end
            default: begin
                state_d = FILL;
                ptr_d   = '0;
            end
        endcase
    end

    // Lane writes, zero-fill above the closing lane, and frame outputs
    always_comb begin
        lane_d  = lane_q;
        count_d = count_q;
        if (accept) begin
            for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
                if (PTR_W'(k) == wr_idx) begin
                    lane_d[k] = in_data;
                end else if (close && (PTR_W'(k) > wr_idx)) begin
                    lane_d[k] = '0;
                end
            end
        end
        if (close) begin
            count_d = CNT_W'(wr_idx) + CNT_W'(1);
        end
        out_data = '0;
        for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
            out_data[k*ADDER_WIDTH +: ADDER_WIDTH] = lane_q[k];
        end
        out_count = count_q;
        out_valid = valid_q;
    end

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// Self-checking bench for adder_tree_operand_loader: vector table, scoreboard and corner-case sequences.
module tb_adder_tree_operand_loader;

    localparam int unsigned W  = 23;
    localparam int unsigned N  = 8;
    localparam int unsigned CW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [N*W-1:0]   out_data;
    logic [CW-1:0]    out_count;
    logic             out_valid;
    logic             out_ready;

    always #5 clk = ~clk;

    adder_tree_operand_loader #(.ADDER_WIDTH(W), .NUM_OPERANDS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [W-1:0] lanes [N];
        int           cnt;
    } frame_t;

    typedef struct {
        int           n;
        logic         use_last;
        logic [W-1:0] words [N];
        logic [W-1:0] exp_lanes [N];
        int           exp_cnt;
    } vec_t;

    frame_t sb_q [$];
    frame_t cur;
    int     cur_n  = 0;
    int     checks = 0;
    int     errors = 0;
    vec_t   vecs [5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] l [N]);
        logic [N*W-1:0] p;
        for (int k = 0; k < N; k++) p[k*W +: W] = l[k];
        return p;
    endfunction

    // Reference framing: collects accepted words, closes on last or on the Nth word
    task automatic model_add(input logic [W-1:0] d, input logic last);
        cur.lanes[cur_n] = d;
        cur_n++;
        if (last || cur_n == N) begin
            for (int k = cur_n; k < N; k++) cur.lanes[k] = '0;
            cur.cnt = cur_n;
            sb_q.push_back(cur);
            cur_n = 0;
        end
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model_add(d, last);
        end
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completed output handshake must match the oldest expected frame
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got frame 0x%0h count %0d, required no frame", out_data, out_count);
            end else begin
                frame_t e;
                logic [N*W-1:0] expd;
                e = sb_q.pop_front();
                expd = pack(e.lanes);
                checks++;
                if (out_data !== expd || out_count !== CW'(e.cnt)) begin
                    errors++;
                    $display("FAIL sb_frame: got 0x%0h/%0d expected 0x%0h/%0d", out_data, out_count, expd, e.cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] expd;
        logic [W-1:0]   l [N];
        logic [25:0]    tsum;

        vecs[0].n = 8; vecs[0].use_last = 1'b0; vecs[0].exp_cnt = 8;
        vecs[0].words     = '{23'h1, 23'h2, 23'h3, 23'h4, 23'h5, 23'h6, 23'h7, 23'h8};
        vecs[0].exp_lanes = '{23'h1, 23'h2, 23'h3, 23'h4, 23'h5, 23'h6, 23'h7, 23'h8};
        vecs[1].n = 3; vecs[1].use_last = 1'b1; vecs[1].exp_cnt = 3;
        vecs[1].words     = '{23'h7FFFFF, 23'h000001, 23'h000010, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0};
        vecs[1].exp_lanes = '{23'h7FFFFF, 23'h000001, 23'h000010, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0};
        vecs[2].n = 8; vecs[2].use_last = 1'b1; vecs[2].exp_cnt = 8;
        vecs[2].words     = '{23'h155555, 23'h2AAAAA, 23'h7FFFFF, 23'h000000,
                              23'h123456, 23'h654321, 23'h0ABCDE, 23'h7EDCBA};
        vecs[2].exp_lanes = '{23'h155555, 23'h2AAAAA, 23'h7FFFFF, 23'h000000,
                              23'h123456, 23'h654321, 23'h0ABCDE, 23'h7EDCBA};
        vecs[3].n = 7; vecs[3].use_last = 1'b1; vecs[3].exp_cnt = 7;
        vecs[3].words     = '{23'h11, 23'h12, 23'h13, 23'h14, 23'h15, 23'h16, 23'h17, 23'h0};
        vecs[3].exp_lanes = '{23'h11, 23'h12, 23'h13, 23'h14, 23'h15, 23'h16, 23'h17, 23'h0};
        vecs[4].n = 1; vecs[4].use_last = 1'b1; vecs[4].exp_cnt = 1;
        vecs[4].words     = '{23'h3C3C3C, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0};
        vecs[4].exp_lanes = '{23'h3C3C3C, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0};

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_count", out_count, 0);
        chk("reset_data", out_data, 0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Table-driven frames with the sink always ready
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                send_word(vecs[i].words[j], vecs[i].use_last && (j == vecs[i].n - 1));
                if (j < vecs[i].n - 1) chk("vec_no_early_valid", out_valid, 0);
            end
            chk("vec_valid", out_valid, 1);
            chk("vec_count", out_count, vecs[i].exp_cnt);
            chk("vec_data", out_data, pack(vecs[i].exp_lanes));
            if (i == 1) begin
                tsum = '0;
                for (int k = 0; k < N; k++) tsum = tsum + 26'(out_data[k*W +: W]);
                chk("tree_sum", tsum, 26'h800010);
            end
            idle(1);
            chk("vec_valid_drop", out_valid, 0);
            idle(1);
        end

        // Backpressure: frame held while the next word waits
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_word(W'(32'h100 + i), 1'b0);
            l[i] = W'(32'h100 + i);
        end
        expd = pack(l);
        in_valid = 1'b1; in_data = 23'h5A5A5A; in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, expd);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        model_add(23'h5A5A5A, 1'b0);
        chk("bp_lane0", out_data[W-1:0], 23'h5A5A5A);
        chk("bp_valid_fall", out_valid, 0);
        for (int i = 1; i < 8; i++) send_word(W'(32'h180 + i), 1'b0);
        chk("bp_next_valid", out_valid, 1);
        idle(2);

        // Back-to-back frames: valid only after every 8th word
        for (int i = 0; i < 24; i++) begin
            send_word(W'(32'h200 + i), 1'b0);
            chk("b2b_valid", out_valid, (i % 8) == 7);
        end
        idle(2);

        // Single-word frames keep out_valid high across consecutive cycles
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < N; k++) l[k] = '0;
            l[0] = W'(32'h0A0A0A + 32'h010101 * i);
            send_word(l[0], 1'b1);
            chk("single_valid", out_valid, 1);
            chk("single_count", out_count, 1);
            chk("single_data", out_data, pack(l));
        end
        idle(1);
        chk("single_valid_drop", out_valid, 0);
        idle(1);

        // Reset in the middle of a partial frame
        for (int i = 0; i < 5; i++) send_word(W'(32'h300 + i), 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", out_valid, 0);
        chk("mid_reset_count", out_count, 0);
        chk("mid_reset_data", out_data, 0);
        cur_n = 0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            send_word(W'(32'h400 + i), 1'b0);
            l[i] = W'(32'h400 + i);
        end
        chk("post_reset_count", out_count, 8);
        chk("post_reset_data", out_data, pack(l));
        idle(3);

        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
